// File: rtl/sha3_pad_feeder.sv
// SHA3 pad10*1 feeder: turns a byte-packed message stream into rate-sized blocks
// for the state FIFO and holds off after each block until the Keccak side acknowledges it.
module sha3_pad_feeder #(
    parameter int         DATA_WIDTH = 16,
    parameter int         RATE       = 1088,
    parameter logic [7:0] DOMAIN     = 8'h06
) (
    input  logic                                  clk,
    input  logic                                  RST_n,
    input  logic [DATA_WIDTH-1:0]                 s_data,
    input  logic [$clog2(DATA_WIDTH/8+1)-1:0]     s_bytes,
    input  logic                                  s_last,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic [DATA_WIDTH-1:0]                 Dout,
    output logic                                  Vout,
    output logic                                  blk_done,
    output logic                                  blk_last,
    input  logic                                  blk_ack,
    output logic                                  busy
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int WPB = RATE / DATA_WIDTH;
    localparam int CW  = $clog2(WPB);
    localparam int BW  = $clog2(BPW + 1);
    localparam logic [CW-1:0]         LAST_IDX = CW'(WPB - 1);
    localparam logic [BW-1:0]         FULL_N   = BW'(BPW);
    localparam logic [DATA_WIDTH-1:0] TOP_BIT  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ABSORB = 2'd1;
    localparam logic [1:0] ST_PAD    = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         word_cnt_q, word_cnt_d;
    logic                  dom_pending_q, dom_pending_d;
    logic                  final_q, final_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  vout_q, vout_d;
    logic                  blk_done_q, blk_done_d;
    logic                  blk_last_q, blk_last_d;
    logic                  s_ready_q, s_ready_d;
    logic                  busy_q, busy_d;
    logic                  emit;
    logic                  ends_msg;
    logic [DATA_WIDTH-1:0] word;

    // Keep the first n bytes, put the domain byte at position n, zero the rest.
    function automatic logic [DATA_WIDTH-1:0] pad_last_word(input logic [DATA_WIDTH-1:0] data,
                                                            input logic [BW-1:0] n);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < BPW; k++) begin
            if (k < int'(n)) begin
                w[8*k +: 8] = data[8*k +: 8];
            end else if (k == int'(n)) begin
                w[8*k +: 8] = DOMAIN;
            end
        end
        return w;
    endfunction

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        dom_pending_d = dom_pending_q;
        final_d       = final_q;
        dout_d        = dout_q;
        vout_d        = 1'b0;
        blk_done_d    = 1'b0;
        blk_last_d    = 1'b0;
        emit          = 1'b0;
        ends_msg      = 1'b0;
        word          = '0;

        case (state_q)
            ST_IDLE, ST_ABSORB: begin
                if (s_valid && s_ready_q) begin
                    emit    = 1'b1;
                    state_d = ST_ABSORB;
                    if (!s_last) begin
                        word = s_data;
                    end else if (s_bytes >= FULL_N) begin
                        // Full last word: the domain byte opens the next word.
                        word          = s_data;
                        dom_pending_d = 1'b1;
                        state_d       = ST_PAD;
                    end else begin
                        word    = pad_last_word(s_data, s_bytes);
                        state_d = ST_PAD;
                        if (word_cnt_q == LAST_IDX) begin
                            word     = word | TOP_BIT;
                            ends_msg = 1'b1;
                        end
                    end
                end
            end
            ST_PAD: begin
                emit = 1'b1;
                if (dom_pending_q) begin
                    word[7:0]     = DOMAIN;
                    dom_pending_d = 1'b0;
                end
                if (word_cnt_q == LAST_IDX) begin
                    word     = word | TOP_BIT;
                    ends_msg = 1'b1;
                end
            end
            default: begin
                if (blk_ack) begin
                    if (final_q) begin
                        state_d = ST_IDLE;
                    end else if (dom_pending_q) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_ABSORB;
                    end
                end
            end
        endcase

        if (emit) begin
            dout_d = word;
            vout_d = 1'b1;
            if (word_cnt_q == LAST_IDX) begin
                word_cnt_d = '0;
                blk_done_d = 1'b1;
                blk_last_d = ends_msg;
                final_d    = ends_msg;
                state_d    = ST_WAIT;
            end else begin
                word_cnt_d = word_cnt_q + CW'(1);
            end
        end

        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_ABSORB);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q       <= ST_IDLE;
            word_cnt_q    <= '0;
            dom_pending_q <= 1'b0;
            final_q       <= 1'b0;
            dout_q        <= '0;
            vout_q        <= 1'b0;
            blk_done_q    <= 1'b0;
            blk_last_q    <= 1'b0;
            s_ready_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            dom_pending_q <= dom_pending_d;
            final_q       <= final_d;
            dout_q        <= dout_d;
            vout_q        <= vout_d;
            blk_done_q    <= blk_done_d;
            blk_last_q    <= blk_last_d;
            s_ready_q     <= s_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign Dout     = dout_q;
    assign Vout     = vout_q;
    assign blk_done = blk_done_q;
    assign blk_last = blk_last_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_sha3_pad_feeder.sv
// Bench for sha3_pad_feeder: drives byte messages and compares the emitted words
// against a byte-level pad10*1 model of the whole padded message.
module tb_sha3_pad_feeder;
    localparam int DW  = 16;
    localparam int RT  = 1088;
    localparam int BPW = DW / 8;
    localparam int WPB = RT / DW;
    localparam int RB  = RT / 8;

    logic          clk = 1'b0;
    logic          RST_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [1:0]    s_bytes = '0;
    logic          s_last = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] Dout;
    logic          Vout;
    logic          blk_done;
    logic          blk_last;
    logic          blk_ack = 1'b0;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  msg[$];
    logic [15:0] exp_w[$];
    logic [15:0] got_w[$];
    bit          got_d[$];
    bit          got_l[$];
    bit          waiting = 1'b0;
    bit          acc = 1'b0;
    int          wait_left = 0;
    int          ack_delay = 0;

    sha3_pad_feeder #(.DATA_WIDTH(DW), .RATE(RT), .DOMAIN(8'h06)) dut (
        .clk(clk), .RST_n(RST_n), .s_data(s_data), .s_bytes(s_bytes), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready), .Dout(Dout), .Vout(Vout),
        .blk_done(blk_done), .blk_last(blk_last), .blk_ack(blk_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, got, exp);
        end
    endtask

    // One clock: record emitted words, police the ack wait, and answer blk_done after ack_delay.
    task automatic tick();
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (blk_ack) blk_ack = 1'b0;
        if (Vout) begin
            got_w.push_back(Dout);
            got_d.push_back(blk_done);
            got_l.push_back(blk_last);
        end
        if (waiting) begin
            chk("wait_ready", got_w.size(), s_ready, 0);
            chk("wait_vout", got_w.size(), Vout, 0);
            chk("wait_busy", got_w.size(), busy, 1);
        end
        if (blk_done) begin
            waiting   = 1'b1;
            wait_left = ack_delay;
        end
        if (waiting) begin
            if (wait_left == 0) begin
                blk_ack = 1'b1;
                waiting = 1'b0;
            end else begin
                wait_left--;
            end
        end
    endtask

    task automatic clr();
        got_w.delete();
        got_d.delete();
        got_l.delete();
    endtask

    task automatic rand_msg(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    endtask

    task automatic send_msg(input bit bubbles, input int stop_after);
        int len, nw, i, guard;
        len = msg.size();
        nw = (len == 0) ? 1 : (len + BPW - 1) / BPW;
        i = 0;
        guard = 0;
        while (i < nw && guard < 5000) begin
            if (stop_after > 0 && got_w.size() >= stop_after) return;
            if (bubbles && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_last  = (i == nw - 1);
                for (int k = 0; k < BPW; k++) begin
                    if (i * BPW + k < len) s_data[8*k +: 8] = msg[i*BPW + k];
                    else s_data[8*k +: 8] = 8'($urandom);
                end
                s_bytes = s_last ? 2'(len - i * BPW) : 2'($urandom_range(0, 2));
            end
            tick();
            if (acc) i++;
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (i < nw) chk("send_timeout", i, 0, 1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || blk_ack || waiting) && g < 3000) begin
            tick();
            g++;
        end
        chk("idle_timeout", g, busy, 0);
    endtask

    // Reference: message || DOMAIN || zeros up to a rate multiple, last byte |= 0x80.
    task automatic check_stream();
        logic [7:0] p[$];
        int n;
        p = msg;
        p.push_back(8'h06);
        while (p.size() % RB != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        exp_w.delete();
        for (int i = 0; i < p.size(); i += BPW) exp_w.push_back({p[i+1], p[i]});
        chk("word_count", msg.size(), got_w.size(), exp_w.size());
        n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            chk("dout", i, got_w[i], exp_w[i]);
            chk("blk_done", i, got_d[i], (i % WPB == WPB - 1));
            chk("blk_last", i, got_l[i], (i == exp_w.size() - 1));
        end
    endtask

    task automatic run_msg(input bit bubbles);
        clr();
        send_msg(bubbles, 0);
        wait_idle();
        check_stream();
    endtask

    initial begin
        #3;
        chk("rst_dout", 0, Dout, 0);
        chk("rst_vout", 0, Vout, 0);
        chk("rst_done", 0, blk_done, 0);
        chk("rst_last", 0, blk_last, 0);
        chk("rst_busy", 0, busy, 0);
        chk("rst_ready", 0, s_ready, 0);
        @(posedge clk);
        #1;
        RST_n = 1'b1;
        tick();
        chk("ready_after_reset", 0, s_ready, 1);

        // empty message
        msg.delete();
        ack_delay = 3;
        run_msg(1'b0);
        if (got_w.size() == WPB) begin
            chk("empty_w0", 0, got_w[0], 16'h0006);
            chk("empty_w67", 67, got_w[67], 16'h8000);
        end

        // "abc"
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        ack_delay = 0;
        run_msg(1'b0);
        if (got_w.size() >= 2) begin
            chk("abc_w0", 0, got_w[0], 16'h6261);
            chk("abc_w1", 1, got_w[1], 16'h0663);
        end

        // 135 bytes: final word takes DOMAIN|0x80
        rand_msg(135);
        msg[134] = 8'hAB;
        ack_delay = 1;
        run_msg(1'b0);
        if (got_w.size() == WPB) chk("m135_w67", 67, got_w[67], 16'h86AB);

        // 136 bytes: padding spills into a second block
        rand_msg(136);
        ack_delay = 2;
        run_msg(1'b1);

        // backpressure: ack withheld 10 cycles while s_valid stays high
        rand_msg(140);
        ack_delay = 10;
        run_msg(1'b0);

        // randomized messages with bubbles and random ack delays
        for (int m = 0; m < 6; m++) begin
            rand_msg($urandom_range(0, 300));
            ack_delay = $urandom_range(0, 5);
            run_msg(1'b1);
        end

        // asynchronous reset mid-block
        rand_msg(100);
        ack_delay = 0;
        clr();
        send_msg(1'b0, 31);
        #2;
        RST_n = 1'b0;
        #1;
        chk("arst_vout", 0, Vout, 0);
        chk("arst_done", 0, blk_done, 0);
        chk("arst_busy", 0, busy, 0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        blk_ack = 1'b0;
        waiting = 1'b0;
        #3;
        RST_n = 1'b1;
        tick();
        tick();
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_msg(1'b0);
        if (got_w.size() > 0) chk("post_rst_w0", 0, got_w[0], 16'h6261);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
